// File: rtl/error_checker.sv
// error_checker
//   Evaluates the fitted line y = b0 + b1*x against the stored samples. It
//   re-reads N (x, y) pairs from a synchronous sample memory, one pair every
//   two cycles, and streams out the saturated residual e = y - (b0 + b1*x)
//   for each pair. When the pass finishes it reports the largest |e| seen.
//   All data is signed Q10.10 (W=20, FRAC=10).
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; returns every output to 0, state IDLE
//   start        begins a pass; only looked at while idle
//   b0, b1       intercept / slope, captured when start is accepted
//   mem_addr     sample-memory read address (held outside READ)
//   x_in, y_in   sample data, valid the cycle after mem_addr
//   err          saturated residual of the most recent sample
//   err_idx      sample index belonging to err
//   err_valid    one-cycle strobe per sample
//   max_abs_err  largest |err| of the current / last pass
//   busy         high while samples are being read and evaluated
//   done         one-cycle strobe, coincident with the last err_valid

module error_checker #(
  parameter int N    = 150,
  parameter int W    = 20,
  parameter int FRAC = 10,
  parameter int AW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  b0,
  input  logic [W-1:0]  b1,
  output logic [AW-1:0] mem_addr,
  input  logic [W-1:0]  x_in,
  input  logic [W-1:0]  y_in,
  output logic [W-1:0]  err,
  output logic [AW-1:0] err_idx,
  output logic          err_valid,
  output logic [W-1:0]  max_abs_err,
  output logic          busy,
  output logic          done
);

  // Width of the unsaturated residual: wide enough that y - yhat never wraps.
  localparam int EW = W + FRAC + 2;
  // Width of the product after dropping the fraction bits.
  localparam int SW = 2 * W - FRAC;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [W-1:0]  POS_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  NEG_MIN  = {1'b1, {(W-1){1'b0}}};

  logic [1:0]    r_state;
  logic [AW-1:0] r_cnt;
  logic [W-1:0]  r_b0;
  logic [W-1:0]  r_b1;
  logic [AW-1:0] r_mem_addr;
  logic [W-1:0]  r_err;
  logic [AW-1:0] r_err_idx;
  logic          r_err_valid;
  logic [W-1:0]  r_max;

  logic signed [2*W-1:0] w_b1_ext;
  logic signed [2*W-1:0] w_x_ext;
  logic signed [2*W-1:0] w_prod;
  logic        [EW-1:0]  w_prod_floor;
  logic        [EW-1:0]  w_yhat;
  logic        [EW-1:0]  w_e;
  logic        [W-1:0]   w_e_sat;
  logic        [W-1:0]   w_e_abs;
  logic                  w_unused_frac;

  // Full-precision product b1*x (fits in 2W bits for W-bit signed operands).
  assign w_b1_ext = {{W{r_b1[W-1]}}, r_b1};
  assign w_x_ext  = {{W{x_in[W-1]}}, x_in};
  assign w_prod   = w_b1_ext * w_x_ext;

  // Dropping the low FRAC bits of a two's-complement value is an arithmetic
  // right shift, i.e. floor division by 2^FRAC.
  assign w_prod_floor  = {{(EW-SW){w_prod[2*W-1]}}, w_prod[2*W-1:FRAC]};
  assign w_unused_frac = ^w_prod[FRAC-1:0];

  assign w_yhat = {{(EW-W){r_b0[W-1]}}, r_b0} + w_prod_floor;
  assign w_e    = {{(EW-W){y_in[W-1]}}, y_in} - w_yhat;

  // Saturate to W bits: the value fits only when bits EW-1..W-1 agree.
  always_comb begin
    w_e_sat = w_e[W-1:0];
    if (w_e[EW-1] && !(&w_e[EW-2:W-1])) begin
      w_e_sat = NEG_MIN;
    end else if (!w_e[EW-1] && (|w_e[EW-2:W-1])) begin
      w_e_sat = POS_MAX;
    end
  end

  // |e|, with the most negative value clamped so it stays representable.
  always_comb begin
    w_e_abs = w_e_sat;
    if (w_e_sat == NEG_MIN) begin
      w_e_abs = POS_MAX;
    end else if (w_e_sat[W-1]) begin
      w_e_abs = '0 - w_e_sat;
    end
  end

  // mem_addr is registered and loaded on the edge entering READ, so it
  // equals cnt for the whole READ cycle and the memory data lands in CALC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_mem_addr  <= '0;
      r_err       <= '0;
      r_err_idx   <= '0;
      r_err_valid <= 1'b0;
      r_max       <= '0;
    end else begin
      r_err_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_b0       <= b0;
            r_b1       <= b1;
            r_cnt      <= '0;
            r_max      <= '0;
            r_mem_addr <= '0;
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_err       <= w_e_sat;
          r_err_idx   <= r_cnt;
          r_err_valid <= 1'b1;
          if (w_e_abs > r_max) begin
            r_max <= w_e_abs;
          end
          if (r_cnt == LAST_IDX) begin
            r_state <= S_DONE;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_mem_addr <= r_cnt + 1'b1;
            r_state    <= S_READ;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr    = r_mem_addr;
  assign err         = r_err;
  assign err_idx     = r_err_idx;
  assign err_valid   = r_err_valid;
  assign max_abs_err = r_max;
  assign busy        = (r_state == S_READ) || (r_state == S_CALC);
  assign done        = (r_state == S_DONE);

endmodule
